// File: rtl/host_if_pkg.sv
// Shared types and constants for the N-port host-interface arbiter.
// Supplies default bus widths when the array-level width macros are not defined.
`ifndef INTERFACE_DATA_WIDTH
`define INTERFACE_DATA_WIDTH 16
`endif
`ifndef INTERFACE_ADDR_WIDTH
`define INTERFACE_ADDR_WIDTH 16
`endif

package host_if_pkg;

   typedef enum logic {
      ARB_FIXED = 1'b0,
      ARB_RR    = 1'b1
   } arb_mode_e;

   localparam int MAX_PORTS = 8;

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Sized for the largest supported port count so every configuration shares one ID type.
   localparam int PORT_ID_W = id_width(MAX_PORTS);
   typedef logic [PORT_ID_W-1:0] port_id_t;

   localparam logic [63:0] TIMEOUT_RDATA = '1;

endpackage

// File: rtl/host_if_id_fifo.sv
// In-order FIFO of requester port IDs for outstanding reads.
// DEPTH must be a power of two, at least 2; push and pop may occur in the same cycle.
module host_if_id_fifo
   import host_if_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic     chip_clk,
   input  logic     asyn_rst_n,
   input  logic     push,
   input  port_id_t push_id,
   input  logic     pop,
   output port_id_t head_id,
   output logic     full,
   output logic     empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   port_id_t      mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign full    = (count == (PW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign head_id = mem[rd_ptr];

   always_ff @(posedge chip_clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_id;
      end
   end

   always_ff @(posedge chip_clk or negedge asyn_rst_n) begin
      if (!asyn_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/host_if_arbiter.sv
// N-port host-interface arbiter: fixed/round-robin grant, registered bus issue, ID-routed read responses.
// Optional read timeout enabled by defining HOST_IF_ARB_RD_TIMEOUT_EN.
module host_if_arbiter
   import host_if_pkg::*;
#(
   parameter int NUM_PORTS   = 2,
   parameter int DW          = `INTERFACE_DATA_WIDTH,
   parameter int AW          = `INTERFACE_ADDR_WIDTH,
   parameter int ARB_MODE    = 0,
   parameter int RD_OT_DEPTH = 4,
   parameter int RD_TIMEOUT  = 255
) (
   input  logic                           chip_clk,
   input  logic                           asyn_rst_n,
   input  logic [NUM_PORTS-1:0]           port_req_valid,
   output logic [NUM_PORTS-1:0]           port_req_ready,
   input  logic [NUM_PORTS-1:0]           port_req_wen,
   input  logic [NUM_PORTS-1:0][AW-1:0]   port_req_addr,
   input  logic [NUM_PORTS-1:0][DW-1:0]   port_req_wdata,
   output logic [NUM_PORTS-1:0]           port_rsp_valid,
   output logic [DW-1:0]                  port_rsp_rdata,
   output logic [AW-1:0]                  interface_addr,
   output logic                           interface_wen,
   output logic [DW-1:0]                  interface_wdata,
   output logic                           interface_ren,
   input  logic [DW-1:0]                  interface_rdata,
   input  logic                           interface_rvalid,
   output logic                           rd_err
);

   localparam bit RR_MODE = (ARB_MODE == int'(ARB_RR));

   logic [NUM_PORTS-1:0] eligible;
   logic [NUM_PORTS-1:0] rsp_valid_d;
   logic                 gnt_valid;
   port_id_t             gnt_idx;
   port_id_t             ptr_q;
   port_id_t             head_id;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 sel_wen;
   logic [AW-1:0]        sel_addr;
   logic [DW-1:0]        sel_wdata;
   logic                 real_pop;
   logic                 timeout_take;
   logic                 pop_any;
   logic                 spurious;

   // Occupancy is the registered count, so a read is never accepted into a full FIFO.
   assign eligible = port_req_valid & (port_req_wen | {NUM_PORTS{~fifo_full}});

   // Round-robin searches ptr..N-1 first, then wraps to 0..ptr-1.
   always_comb begin
      gnt_valid      = 1'b0;
      gnt_idx        = '0;
      port_req_ready = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (!gnt_valid && eligible[i] && (!RR_MODE || i >= int'(ptr_q))) begin
            gnt_valid         = 1'b1;
            gnt_idx           = port_id_t'(i);
            port_req_ready[i] = 1'b1;
         end
      end
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (RR_MODE && !gnt_valid && eligible[i]) begin
            gnt_valid         = 1'b1;
            gnt_idx           = port_id_t'(i);
            port_req_ready[i] = 1'b1;
         end
      end
   end

   always_comb begin
      sel_wen   = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (port_req_ready[i]) begin
            sel_wen   = port_req_wen[i];
            sel_addr  = port_req_addr[i];
            sel_wdata = port_req_wdata[i];
         end
      end
   end

   host_if_id_fifo #(
      .DEPTH (RD_OT_DEPTH)
   ) u_id_fifo (
      .chip_clk   (chip_clk),
      .asyn_rst_n (asyn_rst_n),
      .push       (gnt_valid & ~sel_wen),
      .push_id    (gnt_idx),
      .pop        (pop_any),
      .head_id    (head_id),
      .full       (fifo_full),
      .empty      (fifo_empty)
   );

   assign real_pop = interface_rvalid & ~fifo_empty;
   assign spurious = interface_rvalid & fifo_empty;
   assign pop_any  = real_pop | timeout_take;

`ifdef HOST_IF_ARB_RD_TIMEOUT_EN
   localparam int TW = $clog2(RD_TIMEOUT + 1);
   logic [TW-1:0] to_cnt_q;

   // A real rvalid in the expiry cycle takes precedence over the synthesised response.
   assign timeout_take = ~fifo_empty & ~interface_rvalid & (to_cnt_q == TW'(RD_TIMEOUT - 1));

   always_ff @(posedge chip_clk or negedge asyn_rst_n) begin
      if (!asyn_rst_n) begin
         to_cnt_q <= '0;
      end else if (pop_any || fifo_empty) begin
         to_cnt_q <= '0;
      end else begin
         to_cnt_q <= to_cnt_q + 1'b1;
      end
   end
`else
   assign timeout_take = 1'b0;
`endif

   always_comb begin
      rsp_valid_d = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         rsp_valid_d[i] = pop_any && (head_id == port_id_t'(i));
      end
   end

   always_ff @(posedge chip_clk or negedge asyn_rst_n) begin
      if (!asyn_rst_n) begin
         ptr_q           <= '0;
         interface_addr  <= '0;
         interface_wdata <= '0;
         interface_wen   <= 1'b0;
         interface_ren   <= 1'b0;
         port_rsp_valid  <= '0;
         port_rsp_rdata  <= '0;
         rd_err          <= 1'b0;
      end else begin
         interface_wen  <= gnt_valid & sel_wen;
         interface_ren  <= gnt_valid & ~sel_wen;
         port_rsp_valid <= rsp_valid_d;
         if (gnt_valid) begin
            interface_addr  <= sel_addr;
            interface_wdata <= sel_wdata;
            ptr_q           <= (gnt_idx == port_id_t'(NUM_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
         end
         if (real_pop) begin
            port_rsp_rdata <= interface_rdata;
         end else if (timeout_take) begin
            port_rsp_rdata <= TIMEOUT_RDATA[DW-1:0];
         end
         if (spurious || timeout_take) begin
            rd_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_host_if_arbiter.sv
// Directed bench: fixed-priority 2-port instance and round-robin 4-port instance of host_if_arbiter.
// The timeout scenario runs only when HOST_IF_ARB_RD_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_host_if_arbiter;

   logic chip_clk;
   logic asyn_rst_n;
   int   checks;
   int   failures;

   logic [1:0]        f_req_valid;
   logic [1:0]        f_req_ready;
   logic [1:0]        f_req_wen;
   logic [1:0][15:0]  f_req_addr;
   logic [1:0][15:0]  f_req_wdata;
   logic [1:0]        f_rsp_valid;
   logic [15:0]       f_rsp_rdata;
   logic [15:0]       f_if_addr;
   logic              f_if_wen;
   logic [15:0]       f_if_wdata;
   logic              f_if_ren;
   logic [15:0]       f_if_rdata;
   logic              f_if_rvalid;
   logic              f_rd_err;

   logic [3:0]        r_req_valid;
   logic [3:0]        r_req_ready;
   logic [3:0]        r_req_wen;
   logic [3:0][15:0]  r_req_addr;
   logic [3:0][15:0]  r_req_wdata;
   logic [3:0]        r_rsp_valid;
   logic [15:0]       r_rsp_rdata;
   logic [15:0]       r_if_addr;
   logic              r_if_wen;
   logic [15:0]       r_if_wdata;
   logic              r_if_ren;
   logic              r_rd_err;

   host_if_arbiter #(
      .NUM_PORTS (2), .DW (16), .AW (16), .ARB_MODE (0), .RD_OT_DEPTH (4), .RD_TIMEOUT (8)
   ) dut_fixed (
      .chip_clk         (chip_clk),
      .asyn_rst_n       (asyn_rst_n),
      .port_req_valid   (f_req_valid),
      .port_req_ready   (f_req_ready),
      .port_req_wen     (f_req_wen),
      .port_req_addr    (f_req_addr),
      .port_req_wdata   (f_req_wdata),
      .port_rsp_valid   (f_rsp_valid),
      .port_rsp_rdata   (f_rsp_rdata),
      .interface_addr   (f_if_addr),
      .interface_wen    (f_if_wen),
      .interface_wdata  (f_if_wdata),
      .interface_ren    (f_if_ren),
      .interface_rdata  (f_if_rdata),
      .interface_rvalid (f_if_rvalid),
      .rd_err           (f_rd_err)
   );

   host_if_arbiter #(
      .NUM_PORTS (4), .DW (16), .AW (16), .ARB_MODE (1), .RD_OT_DEPTH (4), .RD_TIMEOUT (8)
   ) dut_rr (
      .chip_clk         (chip_clk),
      .asyn_rst_n       (asyn_rst_n),
      .port_req_valid   (r_req_valid),
      .port_req_ready   (r_req_ready),
      .port_req_wen     (r_req_wen),
      .port_req_addr    (r_req_addr),
      .port_req_wdata   (r_req_wdata),
      .port_rsp_valid   (r_rsp_valid),
      .port_rsp_rdata   (r_rsp_rdata),
      .interface_addr   (r_if_addr),
      .interface_wen    (r_if_wen),
      .interface_wdata  (r_if_wdata),
      .interface_ren    (r_if_ren),
      .interface_rdata  (16'h0000),
      .interface_rvalid (1'b0),
      .rd_err           (r_rd_err)
   );

   initial chip_clk = 1'b0;
   always #5 chip_clk = ~chip_clk;

   task automatic tick();
      @(posedge chip_clk);
      #1;
   endtask

   task automatic test_reset();
      asyn_rst_n  = 1'b0;
      f_req_valid = '0; f_req_wen = '0; f_req_addr = '0; f_req_wdata = '0;
      f_if_rdata  = '0; f_if_rvalid = 1'b0;
      r_req_valid = '0; r_req_wen = '0; r_req_addr = '0; r_req_wdata = '0;
      #12;
      checks++;
      if ({f_if_wen, f_if_ren, f_rd_err, f_rsp_valid} !== 5'b0) begin
         failures++; $display("[TB] FAIL reset_ctrl: got %b expected 00000", {f_if_wen, f_if_ren, f_rd_err, f_rsp_valid});
      end
      checks++;
      if ({f_if_addr, f_if_wdata, f_rsp_rdata} !== 48'h0) begin
         failures++; $display("[TB] FAIL reset_data: got %h expected 0", {f_if_addr, f_if_wdata, f_rsp_rdata});
      end
      checks++;
      if ({r_if_wen, r_if_ren, r_rd_err, r_rsp_valid, r_req_ready} !== 11'b0) begin
         failures++; $display("[TB] FAIL reset_rr: got %b expected 0", {r_if_wen, r_if_ren, r_rd_err, r_rsp_valid, r_req_ready});
      end
      @(negedge chip_clk);
      asyn_rst_n = 1'b1;
      tick();
   endtask

   task automatic test_fixed_priority();
      f_req_valid = 2'b11; f_req_wen = 2'b11;
      f_req_addr[0] = 16'h0010; f_req_wdata[0] = 16'hAAAA;
      f_req_addr[1] = 16'h0020; f_req_wdata[1] = 16'h5555;
      #1;
      checks++;
      if (f_req_ready !== 2'b01) begin
         failures++; $display("[TB] FAIL fixed_ready0: got %b expected 01", f_req_ready);
      end
      tick();
      f_req_valid = 2'b10;
      #1;
      checks++;
      if ({f_if_wen, f_if_addr, f_if_wdata} !== {1'b1, 16'h0010, 16'hAAAA}) begin
         failures++; $display("[TB] FAIL fixed_issue0: got %h expected 1_0010_aaaa", {f_if_wen, f_if_addr, f_if_wdata});
      end
      checks++;
      if (f_req_ready !== 2'b10) begin
         failures++; $display("[TB] FAIL fixed_ready1: got %b expected 10", f_req_ready);
      end
      tick();
      f_req_valid = 2'b00;
      checks++;
      if ({f_if_wen, f_if_addr, f_if_wdata} !== {1'b1, 16'h0020, 16'h5555}) begin
         failures++; $display("[TB] FAIL fixed_issue1: got %h expected 1_0020_5555", {f_if_wen, f_if_addr, f_if_wdata});
      end
      tick();
      checks++;
      if ({f_if_wen, f_if_ren, f_if_addr, f_if_wdata} !== {2'b00, 16'h0020, 16'h5555}) begin
         failures++; $display("[TB] FAIL fixed_hold: got %h expected 0_0020_5555", {f_if_wen, f_if_ren, f_if_addr, f_if_wdata});
      end
   endtask

   task automatic test_round_robin();
      int         cnt [4];
      logic [3:0] exp_ready;
      for (int i = 0; i < 4; i++) begin
         cnt[i] = 0;
         r_req_addr[i]  = 16'h0100 + 16'(i);
         r_req_wdata[i] = 16'h0A00 + 16'(i);
      end
      r_req_valid = 4'b1111; r_req_wen = 4'b1111;
      for (int c = 0; c < 8; c++) begin
         exp_ready = 4'b0001 << (c % 4);
         #1;
         checks++;
         if (r_req_ready !== exp_ready) begin
            failures++; $display("[TB] FAIL rr_grant cycle %0d: got %b expected %b", c, r_req_ready, exp_ready);
         end
         for (int i = 0; i < 4; i++) cnt[i] += int'(r_req_ready[i]);
         tick();
         checks++;
         if ({r_if_wen, r_if_addr} !== {1'b1, 16'h0100 + 16'(c % 4)}) begin
            failures++; $display("[TB] FAIL rr_issue cycle %0d: got %h expected 1_%h", c, {r_if_wen, r_if_addr}, 16'h0100 + 16'(c % 4));
         end
      end
      r_req_valid = '0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (cnt[i] != 2) begin
            failures++; $display("[TB] FAIL rr_share port %0d: got %0d expected 2", i, cnt[i]);
         end
      end
      tick();
   endtask

   task automatic test_read_routing();
      logic [1:0] exp_rsp;
      f_req_valid = 2'b11; f_req_wen = 2'b00;
      f_req_addr[0] = 16'h0030; f_req_addr[1] = 16'h0040;
      #1;
      checks++;
      if (f_req_ready !== 2'b01) begin
         failures++; $display("[TB] FAIL rd_ready0: got %b expected 01", f_req_ready);
      end
      tick();
      for (int c = 0; c < 9; c++) begin
         exp_rsp = (c == 4) ? 2'b01 : (c == 5) ? 2'b10 : 2'b00;
         checks++;
         if (f_rsp_valid !== exp_rsp) begin
            failures++; $display("[TB] FAIL rd_rsp_valid cycle %0d: got %b expected %b", c, f_rsp_valid, exp_rsp);
         end
         if (c == 4) begin
            checks++;
            if (f_rsp_rdata !== 16'h1234) begin
               failures++; $display("[TB] FAIL rd_rdata0: got %h expected 1234", f_rsp_rdata);
            end
         end
         if (c == 5) begin
            checks++;
            if (f_rsp_rdata !== 16'hBEEF) begin
               failures++; $display("[TB] FAIL rd_rdata1: got %h expected beef", f_rsp_rdata);
            end
         end
         if (c < 2) begin
            checks++;
            if ({f_if_ren, f_if_wen, f_if_addr} !== {2'b10, (c == 0) ? 16'h0030 : 16'h0040}) begin
               failures++; $display("[TB] FAIL rd_issue cycle %0d: got %h", c, {f_if_ren, f_if_wen, f_if_addr});
            end
         end
         f_req_valid = (c == 0) ? 2'b10 : 2'b00;
         f_if_rvalid = (c == 3) || (c == 4);
         f_if_rdata  = (c == 3) ? 16'h1234 : (c == 4) ? 16'hBEEF : 16'hDEAD;
         if (c == 0) begin
            #1;
            checks++;
            if (f_req_ready !== 2'b10) begin
               failures++; $display("[TB] FAIL rd_ready1: got %b expected 10", f_req_ready);
            end
         end
         tick();
      end
      f_if_rvalid = 1'b0;
      checks++;
      if (f_rd_err !== 1'b0) begin
         failures++; $display("[TB] FAIL rd_err_clean: got %b expected 0", f_rd_err);
      end
   endtask

   task automatic test_outstanding_full();
      logic [1:0] exp_ready;
      f_req_wen = 2'b10;
      f_req_addr[0] = 16'h0060; f_req_addr[1] = 16'h0050; f_req_wdata[1] = 16'h7777;
      for (int c = 0; c < 8; c++) begin
         exp_ready = (c < 4 || c == 7) ? 2'b01 : (c == 5) ? 2'b10 : 2'b00;
         f_req_valid = {(c == 5), 1'b1};
         f_if_rvalid = (c == 6);
         f_if_rdata  = 16'h0066;
         #1;
         checks++;
         if (f_req_ready !== exp_ready) begin
            failures++; $display("[TB] FAIL ot_ready cycle %0d: got %b expected %b", c, f_req_ready, exp_ready);
         end
         tick();
         if (c == 5) begin
            checks++;
            if ({f_if_wen, f_if_addr, f_if_wdata} !== {1'b1, 16'h0050, 16'h7777}) begin
               failures++; $display("[TB] FAIL ot_write_issue: got %h expected 1_0050_7777", {f_if_wen, f_if_addr, f_if_wdata});
            end
         end
         if (c == 6) begin
            checks++;
            if ({f_rsp_valid, f_rsp_rdata} !== {2'b01, 16'h0066}) begin
               failures++; $display("[TB] FAIL ot_rsp: got %h expected 1_0066", {f_rsp_valid, f_rsp_rdata});
            end
         end
      end
      f_req_valid = '0;
      f_if_rvalid = 1'b1;
      repeat (4) tick();
      f_if_rvalid = 1'b0;
      tick();
      checks++;
      if (f_rd_err !== 1'b0) begin
         failures++; $display("[TB] FAIL ot_rd_err: got %b expected 0", f_rd_err);
      end
   endtask

   task automatic test_spurious_rvalid();
      f_if_rvalid = 1'b1;
      f_if_rdata  = 16'hCAFE;
      tick();
      f_if_rvalid = 1'b0;
      checks++;
      if ({f_rsp_valid, f_rd_err} !== 3'b001) begin
         failures++; $display("[TB] FAIL spur_flag: got %b expected 001", {f_rsp_valid, f_rd_err});
      end
      repeat (3) tick();
      checks++;
      if (f_rd_err !== 1'b1) begin
         failures++; $display("[TB] FAIL spur_sticky: got %b expected 1", f_rd_err);
      end
      asyn_rst_n = 1'b0;
      #2;
      checks++;
      if (f_rd_err !== 1'b0) begin
         failures++; $display("[TB] FAIL spur_reset: got %b expected 0", f_rd_err);
      end
      asyn_rst_n = 1'b1;
      tick();
   endtask

`ifdef HOST_IF_ARB_RD_TIMEOUT_EN
   task automatic test_timeout();
      f_req_valid = 2'b01; f_req_wen = 2'b00; f_req_addr[0] = 16'h0070;
      tick();
      f_req_valid = 2'b00;
      checks++;
      if (f_if_ren !== 1'b1) begin
         failures++; $display("[TB] FAIL to_issue: got %b expected 1", f_if_ren);
      end
      repeat (7) tick();
      checks++;
      if (f_rsp_valid !== 2'b00) begin
         failures++; $display("[TB] FAIL to_early: got %b expected 00", f_rsp_valid);
      end
      tick();
      checks++;
      if ({f_rsp_valid, f_rsp_rdata, f_rd_err} !== {2'b01, 16'hFFFF, 1'b1}) begin
         failures++; $display("[TB] FAIL to_rsp: got %h expected 1_ffff_1", {f_rsp_valid, f_rsp_rdata, f_rd_err});
      end
      tick();
   endtask
`endif

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_fixed_priority();
      test_round_robin();
      test_read_routing();
      test_outstanding_full();
      test_spurious_rvalid();
`ifdef HOST_IF_ARB_RD_TIMEOUT_EN
      test_timeout();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
